// File: rtl/mult_hilo_unit.sv
// Iterative shift-add unsigned multiplier owning the architectural HI/LO pair.
// One product bit is retired per cycle; HI/LO update only on completion.
module mult_hilo_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mul,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, acc, mplr;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_nxt, mplr_nxt;
    logic               last;

    // Sum is one bit wider so the carry survives into the shifted accumulator.
    assign sum      = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
    assign acc_nxt  = sum[WIDTH:1];
    assign mplr_nxt = {sum[0], mplr[WIDTH-1:1]};
    assign last     = (cnt == CNT_W'(1));
    assign busy     = (state == RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (mul) state_nxt = RUN;
            RUN:  if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            mplr  <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul) begin
                        mcand <= op_a;
                        acc   <= '0;
                        mplr  <= op_b;
                        cnt   <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    mplr <= mplr_nxt;
                    cnt  <= cnt - CNT_W'(1);
                    if (last) begin
                        hi   <= acc_nxt;
                        lo   <= mplr_nxt;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit at WIDTH=16 with hand-computed products.
module tb_mult_hilo_unit;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mul;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] hi, lo;
    logic             busy, done;

    int checks   = 0;
    int failures = 0;

    mult_hilo_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .mul(mul), .op_a(op_a), .op_b(op_b),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a start; returns at the first busy cycle with operands scrambled.
    task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        mul = 1'b1; op_a = a; op_b = b;
        @(negedge clk);
        mul = 1'b0;
        op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
    endtask

    // Walk the busy window, checking hi/lo hold and done stays low, then check the result.
    task automatic run_to_done(input string tag, input int pulse_at,
                               input logic [WIDTH-1:0] prev_hi, input logic [WIDTH-1:0] prev_lo,
                               input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
        int n = 0;
        while (busy && n < 40) begin
            chk({tag, "_hold_hi"}, 32'(hi), 32'(prev_hi));
            chk({tag, "_hold_lo"}, 32'(lo), 32'(prev_lo));
            chk({tag, "_done_low"}, 32'(done), 0);
            n++;
            if (pulse_at >= 0) begin
                if (n == pulse_at) begin
                    mul = 1'b1; op_a = 16'd7; op_b = 16'd7;
                end else begin
                    mul = 1'b0;
                end
            end
            @(negedge clk);
        end
        if (pulse_at >= 0) mul = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(n), 32'(WIDTH));
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_hi"}, 32'(hi), 32'(exp_hi));
        chk({tag, "_lo"}, 32'(lo), 32'(exp_lo));
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; mul = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 32'(hi), 0);
        chk("rst_lo", 32'(lo), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;

        // 1: 3*5
        start(16'd3, 16'd5);
        chk("t1_busy", 32'(busy), 1);
        run_to_done("t1", -1, 16'h0000, 16'h0000, 16'h0000, 16'h000F);
        @(negedge clk);
        chk("t1_done_once", 32'(done), 0);

        // 2: max operands, carry path
        start(16'hFFFF, 16'hFFFF);
        run_to_done("t2", -1, 16'h0000, 16'h000F, 16'hFFFE, 16'h0001);

        // 3: stray mul during busy cycle 5 must be ignored
        start(16'h1234, 16'h0010);
        run_to_done("t3", 5, 16'hFFFE, 16'h0001, 16'h0001, 16'h2340);
        @(negedge clk);
        chk("t3_idle_after", 32'(busy), 0);

        // 4: reset at busy cycle 8 aborts with no done
        start(16'h00FF, 16'h0100);
        repeat (7) @(negedge clk);
        chk("t4_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(done), 0);
        chk("t4_hi", 32'(hi), 0);
        chk("t4_lo", 32'(lo), 0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("t4_no_done", 32'(pulses), 0);
        chk("t4_hi_still0", 32'(hi), 0);

        // 5: mul held high -> restart accepted in the done cycle
        @(negedge clk);
        mul = 1'b1; op_a = 16'd2; op_b = 16'd3;
        @(negedge clk);
        run_to_done("t5a", -1, 16'h0000, 16'h0000, 16'h0000, 16'h0006);
        @(negedge clk);
        mul = 1'b0;
        chk("t5_restart_busy", 32'(busy), 1);
        chk("t5_restart_done", 32'(done), 0);
        run_to_done("t5b", -1, 16'h0000, 16'h0006, 16'h0000, 16'h0006);

        // 6: zero multiplier takes full latency, single done pulse
        start(16'hABCD, 16'h0000);
        run_to_done("t6", -1, 16'h0000, 16'h0006, 16'h0000, 16'h0000);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("t6_single_done", 32'(pulses), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
